// File: rtl/imu_spi_sequencer.sv
// SB_SPI register-level sequencer: one-time init, then CS/command/data-byte bursts over the system bus.
// Optional SPI_SEQ_TIMEOUT_EN bounds SPISR polling per byte and raises a sticky err_timeout.
module imu_spi_sequencer #(
    parameter logic [23:0] SPI_BASE  = 24'h030000,
    parameter logic [7:0]  BR_VAL    = 8'h05,
    parameter logic [7:0]  CR2_VAL   = 8'hC0,
    parameter logic [7:0]  CS_ON_VAL = 8'h0E,
    parameter int          LEN_W     = 4,
    parameter logic [15:0] POLL_MAX  = 16'd1023
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [6:0]       rd_addr,
    input  logic [LEN_W-1:0] rd_len,
    output logic             busy,
    output logic             done,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             err_timeout,
    output logic [23:0]      address,
    output logic [31:0]      write_data,
    output logic [3:0]       wstrb,
    output logic             valid,
    input  logic             ready,
    input  logic [31:0]      read_data,
    output logic [3:0]       state_dbg
);
    // Bus handshake: a request is held stable while valid=1 and ready=0; it completes on the
    // cycle ready is sampled 1, and a new request starts only once ready is sampled 0 again.
    typedef enum logic [3:0] {
        S_INIT_CR1, S_INIT_BR, S_INIT_CR2, S_IDLE, S_CS_ON,
        S_TX, S_POLL, S_RX, S_CS_OFF, S_DONE
    } state_t;

    state_t           state, state_n;
    logic             valid_n;
    logic [23:0]      address_n;
    logic [31:0]      write_data_n;
    logic [3:0]       wstrb_n;
    logic [6:0]       addr_q, addr_n;
    logic [LEN_W-1:0] len_q, len_n, cnt_q, cnt_n, cnt_inc;
    logic             cmd_q, cmd_n;
    logic [7:0]       rx_data_n;
    logic             rx_valid_n;
    logic [3:0]       acc_reg;
    logic [7:0]       acc_data;
    logic             acc_wr;
    logic             is_access, ack;
`ifdef SPI_SEQ_TIMEOUT_EN
    logic [15:0]      poll_cnt, poll_n;
    logic             err_q, err_n;
    logic             unused_bits;
    assign unused_bits = ^read_data[31:8];
    assign err_timeout = err_q;
`else
    logic             unused_bits;
    assign unused_bits = ^{read_data[31:8], POLL_MAX};
    assign err_timeout = 1'b0;
`endif

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign state_dbg = state;
    assign is_access = (state != S_IDLE) && (state != S_DONE);
    assign ack       = is_access && valid && ready;
    assign cnt_inc   = cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};

    // Register and value of the bus access belonging to each access state.
    always_comb begin
        acc_reg  = 4'h0;
        acc_data = 8'h00;
        acc_wr   = 1'b1;
        case (state)
            S_INIT_CR1: begin acc_reg = 4'h9; acc_data = 8'h80;     end
            S_INIT_BR:  begin acc_reg = 4'hB; acc_data = BR_VAL;    end
            S_INIT_CR2: begin acc_reg = 4'hA; acc_data = CR2_VAL;   end
            S_CS_ON:    begin acc_reg = 4'hF; acc_data = CS_ON_VAL; end
            S_TX:       begin acc_reg = 4'hD; acc_data = cmd_q ? {1'b1, addr_q} : 8'h00; end
            S_POLL:     begin acc_reg = 4'hC; acc_wr = 1'b0; end
            S_RX:       begin acc_reg = 4'hE; acc_wr = 1'b0; end
            S_CS_OFF:   begin acc_reg = 4'hF; acc_data = 8'h0F;     end
            default: ;
        endcase
    end

    always_comb begin
        state_n      = state;
        valid_n      = valid;
        address_n    = address;
        write_data_n = write_data;
        wstrb_n      = wstrb;
        addr_n       = addr_q;
        len_n        = len_q;
        cnt_n        = cnt_q;
        cmd_n        = cmd_q;
        rx_data_n    = rx_data;
        rx_valid_n   = 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
        poll_n       = poll_cnt;
        err_n        = err_q;
`endif
        if (is_access && !valid && !ready) begin
            valid_n      = 1'b1;
            address_n    = SPI_BASE + {18'd0, acc_reg, 2'b00};
            write_data_n = {24'd0, acc_data};
            wstrb_n      = {3'b000, acc_wr};
        end
        if (ack) valid_n = 1'b0;

        case (state)
            S_INIT_CR1: if (ack) state_n = S_INIT_BR;
            S_INIT_BR:  if (ack) state_n = S_INIT_CR2;
            S_INIT_CR2: if (ack) state_n = S_IDLE;
            S_IDLE: begin
                if (start) begin
                    addr_n  = rd_addr;
                    len_n   = (rd_len == '0) ? {{(LEN_W-1){1'b0}}, 1'b1} : rd_len;
                    cnt_n   = '0;
                    cmd_n   = 1'b1;
                    state_n = S_CS_ON;
                end
            end
            S_CS_ON: if (ack) state_n = S_TX;
            S_TX: begin
                if (ack) begin
                    state_n = S_POLL;
`ifdef SPI_SEQ_TIMEOUT_EN
                    poll_n  = 16'd0;
`endif
                end
            end
            S_POLL: begin
                if (ack) begin
                    if (read_data[3]) begin
                        state_n = S_RX;
                    end
`ifdef SPI_SEQ_TIMEOUT_EN
                    else if (poll_cnt == POLL_MAX - 16'd1) begin
                        err_n   = 1'b1;
                        state_n = S_CS_OFF;
                    end else begin
                        poll_n  = poll_cnt + 16'd1;
                    end
`endif
                end
            end
            S_RX: begin
                if (ack) begin
                    // The byte clocked in during the command byte is meaningless and dropped.
                    if (cmd_q) begin
                        cmd_n   = 1'b0;
                        state_n = S_TX;
                    end else begin
                        rx_valid_n = 1'b1;
                        rx_data_n  = read_data[7:0];
                        cnt_n      = cnt_inc;
                        state_n    = (cnt_inc == len_q) ? S_CS_OFF : S_TX;
                    end
                end
            end
            S_CS_OFF: if (ack) state_n = S_DONE;
            S_DONE:   state_n = S_IDLE;
            default:  state_n = S_INIT_CR1;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_INIT_CR1;
            valid      <= 1'b0;
            address    <= 24'd0;
            write_data <= 32'd0;
            wstrb      <= 4'd0;
            addr_q     <= 7'd0;
            len_q      <= '0;
            cnt_q      <= '0;
            cmd_q      <= 1'b0;
            rx_data    <= 8'd0;
            rx_valid   <= 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
            poll_cnt   <= 16'd0;
            err_q      <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            valid      <= valid_n;
            address    <= address_n;
            write_data <= write_data_n;
            wstrb      <= wstrb_n;
            addr_q     <= addr_n;
            len_q      <= len_n;
            cnt_q      <= cnt_n;
            cmd_q      <= cmd_n;
            rx_data    <= rx_data_n;
            rx_valid   <= rx_valid_n;
`ifdef SPI_SEQ_TIMEOUT_EN
            poll_cnt   <= poll_n;
            err_q      <= err_n;
`endif
        end
    end
endmodule

// File: tb/tb_imu_spi_sequencer.sv
// Scoreboard bench for imu_spi_sequencer: a scripted bus model answers accesses; monitors pop expected queues.
module tb_imu_spi_sequencer;
  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [6:0]  rd_addr;
  logic [3:0]  rd_len;
  logic        busy, done, rx_valid, err_timeout, valid, ready;
  logic [7:0]  rx_data;
  logic [23:0] address;
  logic [31:0] write_data, read_data;
  logic [3:0]  wstrb, state_dbg;

  imu_spi_sequencer #(.POLL_MAX(16'd4)) dut (
    .clock(clock), .reset(reset), .start(start), .rd_addr(rd_addr), .rd_len(rd_len),
    .busy(busy), .done(done), .rx_data(rx_data), .rx_valid(rx_valid),
    .err_timeout(err_timeout), .address(address), .write_data(write_data),
    .wstrb(wstrb), .valid(valid), .ready(ready), .read_data(read_data),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  logic [32:0] exp_q[$];      // {address, write byte, is_write}
  logic [7:0]  exp_rx_q[$];
  logic [7:0]  rx_script[$];
  logic [7:0]  data_tbl[16];
  logic [7:0]  sr_value = 8'h08;
  int latency = 2;
  int hold_extra = 0;
  int done_seen = 0;
  int exp_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // ---------------- bus model ----------------
  initial begin : bus_model
    int wcnt;
    int hcnt;
    wcnt = 0;
    hcnt = 0;
    ready = 1'b0;
    read_data = 32'd0;
    forever begin
      @(negedge clock);
      if (reset) begin
        ready = 1'b0;
        wcnt = 0;
        hcnt = 0;
      end else if (ready) begin
        check("valid_low_while_ready", valid, 1'b0);
        if (hcnt > 0) hcnt--;
        else ready = 1'b0;
      end else if (valid) begin
        wcnt++;
        if (wcnt >= latency) begin
          wcnt = 0;
          hcnt = hold_extra;
          ready = 1'b1;
          if (address == 24'h030030) read_data = {24'd0, sr_value};
          else if (address == 24'h030038) read_data = (rx_script.size() > 0) ? {24'd0, rx_script.pop_front()} : 32'h0000_00EE;
          else read_data = 32'd0;
        end
      end
    end
  end

  // ---------------- monitors ----------------
  initial begin : bus_monitor
    logic        valid_prev;
    logic [32:0] e;
    valid_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        valid_prev = 1'b0;
      end else begin
        if (valid && !valid_prev) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL bus_unexpected: got addr %0h data %0h want no access", address, write_data);
          end else begin
            e = exp_q.pop_front();
            check("bus_addr", address, e[32:9]);
            check("bus_wstrb", wstrb, e[0] ? 4'b0001 : 4'b0000);
            check("bus_wdata_hi", write_data[31:8], 24'd0);
            if (e[0]) check("bus_wdata", write_data[7:0], e[8:1]);
          end
        end
        valid_prev = valid;
      end
    end
  end

  initial begin : rx_monitor
    forever begin
      @(negedge clock);
      if (!reset && done) done_seen++;
      if (!reset && rx_valid) begin
        if (exp_rx_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_unexpected: got %0h want no rx_valid", rx_data);
        end else begin
          check("rx_data", rx_data, exp_rx_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_access(input logic [23:0] a, input logic [7:0] d, input logic wr);
    exp_q.push_back({a, d, wr});
  endtask

  task automatic push_init();
    push_access(24'h030024, 8'h80, 1'b1);
    push_access(24'h03002C, 8'h05, 1'b1);
    push_access(24'h030028, 8'hC0, 1'b1);
  endtask

  task automatic queue_burst(input logic [6:0] a, input int n);
    push_access(24'h03003C, 8'h0E, 1'b1);
    rx_script.push_back(8'hAA);
    for (int k = 0; k <= n; k++) begin
      push_access(24'h030034, (k == 0) ? {1'b1, a} : 8'h00, 1'b1);
      push_access(24'h030030, 8'h00, 1'b0);
      push_access(24'h030038, 8'h00, 1'b0);
      if (k > 0) begin
        rx_script.push_back(data_tbl[k-1]);
        exp_rx_q.push_back(data_tbl[k-1]);
      end
    end
    push_access(24'h03003C, 8'h0F, 1'b1);
  endtask

  task automatic pulse_start(input logic [6:0] a, input logic [3:0] len);
    @(negedge clock);
    start = 1'b1;
    rd_addr = a;
    rd_len = len;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clock);
      if (!busy) break;
    end
    check("wait_idle", busy, 1'b0);
  endtask

  task automatic wait_done(input int max_cycles, input bit poke);
    logic got;
    got = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clock);
      if (done) begin
        got = 1'b1;
        if (poke) begin
          start = 1'b1;
          rd_addr = 7'h55;
          rd_len = 4'd2;
          @(negedge clock);
          start = 1'b0;
        end
        break;
      end
    end
    check("wait_done", got, 1'b1);
  endtask

  task automatic run_burst(input logic [6:0] a, input logic [3:0] len, input int n, input bit poke);
    wait_idle(200);
    queue_burst(a, n);
    exp_done++;
    pulse_start(a, len);
    if (poke) begin
      repeat (5) @(negedge clock);
      start = 1'b1;
      rd_addr = 7'h7F;
      rd_len = 4'd9;
      @(negedge clock);
      start = 1'b0;
    end
    wait_done(2000, poke);
    repeat (4) @(negedge clock);
    check("bus_q_empty", exp_q.size(), 0);
    check("rx_q_empty", exp_rx_q.size(), 0);
    check("done_count", done_seen, exp_done);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic got;
    reset = 1'b1;
    start = 1'b0;
    rd_addr = 7'd0;
    rd_len = 4'd0;
    for (int i = 0; i < 16; i++) data_tbl[i] = 8'(i + 1);
    repeat (3) @(negedge clock);
    check("rst_valid", valid, 1'b0);
    check("rst_address", address, 24'd0);
    check("rst_write_data", write_data, 32'd0);
    check("rst_wstrb", wstrb, 4'd0);
    check("rst_busy", busy, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, 8'd0);
    check("rst_err_timeout", err_timeout, 1'b0);

    // Init sequence after reset release.
    push_init();
    reset = 1'b0;
    wait_idle(200);
    check("init_drained", exp_q.size(), 0);

    // Single data byte; the command-byte response 8'hAA must be dropped.
    data_tbl[0] = 8'h68;
    run_burst(7'h0F, 4'd1, 1, 1'b0);
    for (int i = 0; i < 16; i++) data_tbl[i] = 8'(i + 1);

    // Length 0 behaves as 1, length 15 delivers 15 bytes.
    run_burst(7'h22, 4'd0, 1, 1'b0);
    run_burst(7'h05, 4'd15, 15, 1'b0);

    // Bus keeps ready high 3 extra cycles after every ack.
    hold_extra = 3;
    run_burst(7'h33, 4'd3, 3, 1'b0);
    hold_extra = 0;

    // start while busy and start on the DONE cycle are both ignored.
    run_burst(7'h41, 4'd2, 2, 1'b1);
    repeat (20) @(negedge clock);
    check("start_on_done_ignored", busy, 1'b0);
    check("no_extra_access", exp_q.size(), 0);

    // Reset while polling SPISR.
    queue_burst(7'h0F, 4);
    pulse_start(7'h0F, 4'd4);
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (valid && address == 24'h030030) begin
        got = 1'b1;
        break;
      end
    end
    check("reached_poll", got, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("reset_valid_async", valid, 1'b0);
    check("reset_busy", busy, 1'b1);
    check("reset_address", address, 24'd0);
    exp_q.delete();
    exp_rx_q.delete();
    rx_script.delete();
    repeat (2) @(negedge clock);
    push_init();
    reset = 1'b0;
    wait_idle(200);
    check("reinit_drained", exp_q.size(), 0);
    check("no_done_on_reset", done_seen, exp_done);

`ifdef SPI_SEQ_TIMEOUT_EN
    // SPISR never reports RRDY: four polls, then CS release and done with no data.
    sr_value = 8'h00;
    push_access(24'h03003C, 8'h0E, 1'b1);
    push_access(24'h030034, 8'h92, 1'b1);
    for (int k = 0; k < 4; k++) push_access(24'h030030, 8'h00, 1'b0);
    push_access(24'h03003C, 8'h0F, 1'b1);
    exp_done++;
    pulse_start(7'h12, 4'd3);
    wait_done(2000, 1'b0);
    repeat (4) @(negedge clock);
    check("timeout_bus_q_empty", exp_q.size(), 0);
    check("timeout_err", err_timeout, 1'b1);
    check("timeout_done_count", done_seen, exp_done);
    check("timeout_busy", busy, 1'b0);
    sr_value = 8'h08;
`else
    check("err_tied_low", err_timeout, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/imu_spi_sequencer.md
Name: imu_spi_sequencer

Overview:
- Bus master that drives the SPI region (address[23:16]=8'h03) of the UP5K hard-IP wrapper over its valid/ready system-bus port.
- Runs the SB_SPI register-level sequence needed to read an IMU register burst: one-time init, then per request CS assert, command byte, N dummy/data bytes, CS release.
- Streams received data bytes to downstream sample logic. Sits directly upstream of the hard-IP wrapper.

Parameters:
- SPI_BASE, 24'h030000, base byte address of the SB_SPI block; register r is at SPI_BASE + (r<<2).
- BR_VAL, 8'h05, value written to SPIBR (0xB).
- CR2_VAL, 8'hC0, value written to SPICR2 (0xA): master, hold CS.
- CS_ON_VAL, 8'h0E, value written to SPICSR (0xF) to assert MCSN0 low.
- LEN_W, 4, width of the burst length field.
- POLL_MAX, 1023, maximum SPISR polls per byte (used only with the optional feature).

Ports:
- clock in 1: system clock.
- reset in 1: asynchronous, active-high reset.
- start in 1: single-cycle request; accepted only when busy=0.
- rd_addr in 7: IMU register address; the command byte is {1'b1, rd_addr}.
- rd_len in LEN_W: number of data bytes; 0 is treated as 1.
- busy out 1: high from init start until done.
- done out 1: one-cycle pulse at the end of a burst.
- rx_data out 8: received data byte.
- rx_valid out 1: one-cycle strobe qualifying rx_data.
- err_timeout out 1: sticky poll-timeout flag.
- address out 24: bus address.
- write_data out 32: bus write data; bits [31:8] are always 0.
- wstrb out 4: 4'b0001 for a write, 4'b0000 for a read.
- valid out 1: bus request.
- ready in 1: bus acknowledge.
- read_data in 32: bus read data; only bits [7:0] are used.

Behaviour:
- Reset values: valid=0, address=0, write_data=0, wstrb=0, busy=1, done=0, rx_valid=0, rx_data=0, err_timeout=0. The FSM goes to INIT_CR1.

Bus sub-sequence, one access:
- REQ: drive address, data and wstrb, then set valid=1.
- Hold all bus signals stable while ready=0.
- On the cycle ready is sampled 1: capture read_data[7:0] on reads, and drop valid the next cycle.
- Do not assert valid for a new access until ready is sampled 0. This means at least 1 idle cycle between accesses.
- A bus access is never abandoned mid-transfer except by reset.

Main FSM, in order, each step one bus access:
- INIT_CR1: write SPICR1 (0x9) = 8'h80 (enable).
- INIT_BR: write SPIBR = BR_VAL.
- INIT_CR2: write SPICR2 = CR2_VAL.
- IDLE: busy=0. When start=1, latch rd_addr and len = max(rd_len,1), and set byte counter = 0.
- CS_ON: write SPICSR = CS_ON_VAL.
- TX: write SPITXDR (0xD). Data is the command byte first, then 8'h00 for each data byte.
- POLL: read SPISR (0xC). Repeat until bit3 (RRDY) = 1.
- RX: read SPIRXDR (0xE).
  - For the command byte, discard the value.
  - For a data byte, pulse rx_valid with rx_data the cycle after ready, then increment the counter.
  - If counter == len, go to CS_OFF; otherwise go to TX.
- CS_OFF: write SPICSR = 8'h0F.
- DONE: done=1 for one cycle, then IDLE.

Boundary conditions:
- start while busy=1 is ignored.
- start on the same cycle DONE completes is ignored (busy is still 1).
- rd_len = max value: exactly 2^LEN_W-1 bytes delivered, with no counter wrap.
- Reset mid-burst: all outputs return to their reset values immediately, valid drops asynchronously, and the FSM re-runs init. No done is issued.
- Total rx_valid pulses per burst equals len exactly.

Optional Feature:
SPI_SEQ_TIMEOUT_EN
- Defined:
  - A counter tracks the SPISR reads in POLL and resets on each TX.
  - When POLL_MAX reads complete without RRDY, set err_timeout=1 (sticky until reset).
  - Skip the remaining bytes, write CS_OFF, then pulse done. The byte that timed out gets no rx_valid.
- Undefined: POLL repeats forever, err_timeout is tied to 0, and the counter logic is absent.

Test Plan:
- Reset release with a bus model that answers in 2 cycles -> writes, in order: addr 24'h030024 data 8'h80; 24'h03002C data 8'h05; 24'h030028 data 8'hC0. Then busy falls to 0.
- start with rd_addr=7'h0F, rd_len=1; SPIRXDR returns 8'hAA, 8'h68 -> TXDR writes 8'h8F, 8'h00; one rx_valid with rx_data=8'h68; SPICSR writes 8'h0E then 8'h0F; one done pulse.
- rd_len=0, then rd_len=15 -> 1 byte and 15 bytes delivered respectively; rx_data matches the scripted values 8'h01..8'h0F.
- Bus model holds ready=1 for 3 extra cycles after each ack -> valid is not reasserted until ready=0; no duplicate accesses.
- Assert reset while in POLL -> valid=0 immediately; after release the three init writes repeat; no done pulse.
- With SPI_SEQ_TIMEOUT_EN and POLL_MAX=4, SPISR always returns 8'h00 -> exactly 4 SPISR reads, err_timeout=1, SPICSR=8'h0F write, done pulse, 0 rx_valid.
